serial_accum: RTL and testbench

Parametrised bit-serial accumulator: the multi-bit successor of the 4-bit serial accumulator. Operands arrive one bit per valid cycle, LSB first. Each operand is added to or subtracted from a WIDTH-bit running total using a single full adder and a registered carry. The block sits between a serial data source (shift-out of a UART or SPI front end) and parallel consumers such as display or compare logic. It adds per-word framing, a done pulse, subtract mode, a sticky overflow flag and synchronous clear, none of which the 4-bit version has.

---
 rtl/serial_accum_pkg.sv | 15 +
 rtl/serial_add_bit.sv | 30 +++
 rtl/serial_accum.sv | 101 ++++++++++
 tb/tb_serial_accum.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_accum_pkg.sv
// rtl/serial_accum_pkg.sv - shared constants and types for the bit-serial accumulator
package serial_accum_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Counter width for any legal WIDTH; WIDTH=2 still needs one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_bit.sv
// rtl/serial_add_bit.sv - one-bit full adder with registered carry for serial arithmetic
module serial_add_bit (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic load,
  input  logic init,
  input  logic en,
  output logic s,
  output logic cout
);

  logic carry;
  logic cin;

  // load substitutes init for the stored carry on the first bit of a word
  assign cin  = load ? init : carry;
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= cout;
    end
  end

endmodule

// File: rtl/serial_accum.sv
// rtl/serial_accum.sv - bit-serial add/subtract accumulator, LSB first, sticky overflow
// Define SERIAL_ACCUM_SAT_EN to saturate on overflow/underflow instead of wrapping.
import serial_accum_pkg::*;

module serial_accum #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  op_t              op_q;
  state_t           state;

  logic             first;
  logic             last;
  logic             op_cur;
  logic             b;
  logic             s;
  logic             k;
  logic             ovf_now;
  logic [WIDTH-1:0] res_wrap;
  logic [WIDTH-1:0] res;

  assign first  = (cnt == '0);
  assign last   = (cnt == LAST);
  // sub is only honoured on the first bit; afterwards the latched op rules
  assign op_cur = first ? sub : (op_q == OP_SUB);
  assign b      = din ^ op_cur;

  serial_add_bit u_add (
    .clk  (clk),
    .rst  (rst | clr),
    .a    (acc[0]),
    .b    (b),
    .load (first),
    .init (op_cur),
    .en   (din_valid),
    .s    (s),
    .cout (k)
  );

  assign res_wrap = {s, acc[WIDTH-1:1]};
  // Add overflows on carry-out; subtract underflows when no carry (borrow).
  assign ovf_now  = op_cur ? ~k : k;

`ifdef SERIAL_ACCUM_SAT_EN
  assign res = ovf_now ? (op_cur ? '0 : '1) : res_wrap;
`else
  assign res = res_wrap;
`endif

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      cnt   <= '0;
      op_q  <= OP_ADD;
      state <= IDLE;
      sum   <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (din_valid) begin
        if (first) begin
          op_q <= op_t'(sub);
        end
        if (last) begin
          acc   <= res;
          sum   <= res;
          cnt   <= '0;
          state <= IDLE;
          done  <= 1'b1;
          if (ovf_now) begin
            ovf <= 1'b1;
          end
        end else begin
          acc   <= res_wrap;
          cnt   <= cnt + 1'b1;
          state <= SHIFT;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_accum.sv
// tb/tb_serial_accum.sv - directed self-checking bench for serial_accum at WIDTH=8
module tb_serial_accum;

`ifdef SERIAL_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] sum;
  logic       done;
  logic       busy;
  logic       ovf;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int d0;

  serial_accum #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .sub       (sub),
    .sum       (sum),
    .done      (done),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic [7:0] v, input int n, input logic op,
                            input bit toggle, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int ng;
        ng = 1 + $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          @(negedge clk);
          din_valid = 1'b0;
          din = 1'($urandom);
          sub = 1'($urandom);
        end
      end
      @(negedge clk);
      din       = v[i];
      din_valid = 1'b1;
      sub       = (i == 0) ? op : (toggle ? ~op : op);
    end
  endtask

  // Returns on the negedge right after the edge that sampled bit 7.
  task automatic word(input logic [7:0] v, input logic op, input bit toggle, input bit gaps);
    drive_bits(v, 8, op, toggle, gaps);
    @(negedge clk);
    din_valid = 1'b0;
    sub = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sum", sum, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);

    // 5 + 3
    d0 = done_seen;
    word(8'd5, 1'b0, 1'b0, 1'b0);
    chk("w5_done", done, 1);
    chk("w5_sum", sum, 5);
    chk("w5_busy", busy, 0);
    @(negedge clk);
    chk("w5_done_low", done, 0);
    chk("w5_done_cnt", done_seen - d0, 1);
    drive_bits(8'd3, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("w3_mid_busy", busy, 1);
    chk("w3_mid_sum", sum, 5);
    din_valid = 1'b0;
    drive_bits(8'd3 >> 4, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    chk("w3_sum", sum, 8);
    chk("w3_done", done, 1);
    chk("w3_ovf", ovf, 0);

    // 200 + 100 overflow
    pulse_clr();
    word(8'd200, 1'b0, 1'b0, 1'b0);
    chk("a200_sum", sum, 200);
    chk("a200_ovf", ovf, 0);
    word(8'd100, 1'b0, 1'b0, 1'b0);
    chk("a100_sum", sum, SAT ? 255 : 44);
    chk("a100_ovf", ovf, 1);

    // 10 - 3 - 20, sub toggled mid-word on the first subtract
    pulse_clr();
    chk("clr_ovf", ovf, 0);
    word(8'd10, 1'b0, 1'b0, 1'b0);
    chk("a10_sum", sum, 10);
    chk("a10_ovf", ovf, 0);
    word(8'd3, 1'b1, 1'b1, 1'b0);
    chk("s3_sum", sum, 7);
    chk("s3_ovf", ovf, 0);
    word(8'd20, 1'b1, 1'b0, 1'b0);
    chk("s20_sum", sum, SAT ? 0 : 243);
    chk("s20_ovf", ovf, 1);

    // gapped 0x5A on top of 100
    pulse_clr();
    word(8'd100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    d0 = done_seen;
    word(8'h5A, 1'b0, 1'b0, 1'b1);
    chk("gap_sum", sum, 190);
    chk("gap_done", done, 1);
    @(negedge clk);
    chk("gap_done_cnt", done_seen - d0, 1);
    chk("gap_ovf", ovf, 0);

    // clr aborts a partial word
    pulse_clr();
    word(8'd9, 1'b0, 1'b0, 1'b0);
    chk("c9_sum", sum, 9);
    @(negedge clk);
    d0 = done_seen;
    drive_bits(8'hFF, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("clr_pre_busy", busy, 1);
    clr = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    din_valid = 1'b0;
    chk("clr_sum", sum, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ovf2", ovf, 0);
    chk("clr_done", done, 0);
    @(negedge clk);
    chk("clr_no_done", done_seen - d0, 0);
    word(8'd9, 1'b0, 1'b0, 1'b0);
    chk("clr_w9_sum", sum, 9);

    // rst mid-word while ovf is set
    word(8'd200, 1'b0, 1'b0, 1'b0);
    word(8'd100, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_ovf", ovf, 1);
    drive_bits(8'hFF, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    chk("mrst_sum", sum, 0);
    chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovf", ovf, 0);
    word(8'd7, 1'b0, 1'b0, 1'b0);
    chk("mrst_w7_sum", sum, 7);
    chk("mrst_w7_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
